param_line_buffer: RTL and testbench

Parametrised successor to the fixed five-row line buffer: stores the last K-1 lines of a raster pixel stream and emits a K-row column slice, packed as K words, on every accepted pixel. The CNN convolution window builder uses these slices. Generalises data width, row count and maximum line length; adds a runtime line width, start-of-frame re-arming, and a ready/valid handshake with backpressure on both sides.

---
 rtl/param_line_buffer.sv | 154 +++++++++++++++
 tb/tb_param_line_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/param_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : param_line_buffer
// Purpose  : Raster line buffer that keeps the last K-1 lines of a pixel
//            stream and emits a K-row column slice for every accepted pixel
//            once K-1 complete lines are stored. Runtime line width,
//            start-of-frame re-arming and ready/valid on both sides.
// Ports    : clk, rst         - clock, asynchronous active-high reset
//            cfg_width_i      - line length, sampled on an accepted SOF pixel
//            d_in_i           - input pixel
//            in_sof_i         - d_in_i is (row 0, col 0) of a new frame
//            in_valid_i       - d_in_i is valid
//            in_ready_o       - block can accept d_in_i
//            d_out_o          - slice; row 0 (newest) in the low word
//            out_eol_o        - slice is from the last column of its line
//            out_valid_o      - d_out_o is valid
//            out_ready_i      - downstream accepts d_out_o
// Revision : 1.0 - initial parametrised release
// ============================================================================
module param_line_buffer #(
  parameter int DATA_W = 32,
  parameter int K      = 5,
  parameter int MAX_W  = 64,
  parameter int CW     = $clog2(MAX_W + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CW-1:0]       cfg_width_i,
  input  logic [DATA_W-1:0]   d_in_i,
  input  logic                in_sof_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [K*DATA_W-1:0] d_out_o,
  output logic                out_eol_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  // Memory address width; the column register is one bit wider so it can
  // also represent MAX_W as a line width.
  localparam int              c_AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int              c_FW    = $clog2(K);
  localparam logic [CW-1:0]   c_MAX_W = CW'(MAX_W);
  localparam logic [c_FW-1:0] c_FULL  = c_FW'(K - 1);

  // Registered state
  logic [CW-1:0]       col_q, col_d;
  logic [CW-1:0]       width_q, width_d;
  logic [c_FW-1:0]     fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic                out_eol_q, out_eol_d;
  logic [K*DATA_W-1:0] d_out_q, d_out_d;

  // Line memories: mem_q[0] holds the most recent complete/partial line.
  logic [DATA_W-1:0]   mem_q [K-1][MAX_W];

  // Combinational helpers
  logic                w_accept;
  logic [CW-1:0]       w_cfg_clamped;
  logic [CW-1:0]       w_col;
  logic [CW-1:0]       w_width;
  logic [c_FW-1:0]     w_fill;
  logic                w_last;
  logic                w_emit;
  logic [c_AW-1:0]     w_addr;
  logic [K*DATA_W-1:0] w_slice;

  // Single output register stage: a slot frees up in the same cycle the
  // downstream drains it.
  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign w_accept   = in_valid_i & in_ready_o;

  assign w_cfg_clamped = ((cfg_width_i == '0) || (cfg_width_i > c_MAX_W))
                       ? c_MAX_W : cfg_width_i;

  // An SOF pixel behaves as column 0 of an empty frame with the new width,
  // so its own emit/last-column decision already uses the re-armed values.
  assign w_col   = in_sof_i ? '0            : col_q;
  assign w_width = in_sof_i ? w_cfg_clamped : width_q;
  assign w_fill  = in_sof_i ? '0            : fill_q;
  assign w_last  = (w_col == (w_width - CW'(1)));
  assign w_emit  = w_accept & (w_fill == c_FULL);
  assign w_addr  = w_col[c_AW-1:0];

  // Slice built from pre-write memory contents (read-before-write).
  assign w_slice[DATA_W-1:0] = d_in_i;
  for (genvar i = 1; i < K; i++) begin : g_slice
    assign w_slice[DATA_W*i +: DATA_W] = mem_q[i-1][w_addr];
  end

  // Line memories are deliberately not reset; fill gates any stale data.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_q[0][w_addr] <= d_in_i;
      for (int j = 1; j < K - 1; j++) begin
        mem_q[j][w_addr] <= mem_q[j-1][w_addr];
      end
    end
  end

  always_comb begin
    col_d       = col_q;
    width_d     = width_q;
    fill_d      = fill_q;
    out_valid_d = out_valid_q;
    out_eol_d   = out_eol_q;
    d_out_d     = d_out_q;

    if (w_accept) begin
      width_d = w_width;
      if (w_last) begin
        col_d  = '0;
        fill_d = (w_fill == c_FULL) ? c_FULL : w_fill + c_FW'(1);
      end else begin
        col_d  = w_col + CW'(1);
        fill_d = w_fill;
      end
    end

    // A new emitting accept wins over a drain, giving back-to-back slices.
    if (w_emit) begin
      out_valid_d = 1'b1;
      out_eol_d   = w_last;
      d_out_d     = w_slice;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      out_eol_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      width_q     <= c_MAX_W;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      d_out_q     <= '0;
    end else begin
      col_q       <= col_d;
      width_q     <= width_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      d_out_q     <= d_out_d;
    end
  end

  assign d_out_o     = d_out_q;
  assign out_eol_o   = out_eol_q;
  assign out_valid_o = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_param_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_line_buffer
// Purpose  : Directed self-checking bench for param_line_buffer with K=5,
//            MAX_W=8, DATA_W=32: fill and first slice, backpressure,
//            mid-line SOF, gapped input, width clamp and mid-line reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_line_buffer;

  localparam int DATA_W = 32;
  localparam int K      = 5;
  localparam int MAX_W  = 8;
  localparam int CW     = $clog2(MAX_W + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic [CW-1:0]       cfg_width;
  logic [DATA_W-1:0]   d_in;
  logic                in_sof;
  logic                in_valid;
  logic                in_ready;
  logic [K*DATA_W-1:0] d_out;
  logic                out_eol;
  logic                out_valid;
  logic                out_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  param_line_buffer #(
    .DATA_W (DATA_W),
    .K      (K),
    .MAX_W  (MAX_W),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_width_i (cfg_width),
    .d_in_i      (d_in),
    .in_sof_i    (in_sof),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .d_out_o     (d_out),
    .out_eol_o   (out_eol),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  // Expected slice; r0 is the newest row (low word).
  function automatic logic [K*DATA_W-1:0] mk(input int r0, input int r1,
                                             input int r2, input int r3,
                                             input int r4);
    return {DATA_W'(r4), DATA_W'(r3), DATA_W'(r2), DATA_W'(r1), DATA_W'(r0)};
  endfunction

  task automatic chk(input string tag, input logic [K*DATA_W-1:0] obs,
                     input logic [K*DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one pixel and let it be accepted on the next edge; outputs are
  // sampled 1 ns after that edge.
  task automatic pix(input int v, input logic sof);
    d_in     = DATA_W'(v);
    in_sof   = sof;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_sof   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    d_in     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_width = '0;
    d_in      = '0;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_eol",   out_eol,   0);
    chk("reset_d_out",     d_out,     0);
    chk("reset_in_ready",  in_ready,  1);
    rst = 1'b0;

    // Fill and first slice, width 4
    cfg_width = 4;
    for (int p = 0; p < 16; p++) begin
      pix(p, p == 0);
      chk($sformatf("fill_valid_p%0d", p), out_valid, 0);
    end
    pix(16, 1'b0);
    chk("first_valid", out_valid, 1);
    chk("first_slice", d_out, mk(16, 12, 8, 4, 0));
    chk("first_eol",   out_eol, 0);
    pix(17, 1'b0);
    chk("p17_slice", d_out, mk(17, 13, 9, 5, 1));

    // Backpressure for three cycles with pixel 18 waiting
    out_ready = 1'b0;
    d_in      = 18;
    in_valid  = 1'b1;
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_c%0d", c), out_valid, 1);
      chk($sformatf("bp_hold_c%0d", c),  d_out, mk(17, 13, 9, 5, 1));
      chk($sformatf("bp_ready_c%0d", c), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("p18_slice", d_out, mk(18, 14, 10, 6, 2));
    chk("p18_eol",   out_eol, 0);
    pix(19, 1'b0);
    chk("p19_slice", d_out, mk(19, 15, 11, 7, 3));
    chk("p19_eol",   out_eol, 1);
    pix(20, 1'b0);
    chk("p20_slice", d_out, mk(20, 16, 12, 8, 4));
    chk("p20_eol",   out_eol, 0);

    // Mid-line SOF with width 3
    cfg_width = 3;
    pix(21, 1'b1);
    chk("sof21_valid", out_valid, 0);
    for (int p = 22; p < 33; p++) begin
      pix(p, 1'b0);
      chk($sformatf("sof_fill_valid_p%0d", p), out_valid, 0);
    end
    pix(33, 1'b0);
    chk("p33_valid", out_valid, 1);
    chk("p33_slice", d_out, mk(33, 30, 27, 24, 21));
    chk("p33_eol",   out_eol, 0);
    pix(34, 1'b0);
    pix(35, 1'b0);
    chk("p35_slice", d_out, mk(35, 32, 29, 26, 23));
    chk("p35_eol",   out_eol, 1);

    // Gapped input, width 4: same slice sequence as the first scenario
    cfg_width = 4;
    for (int p = 0; p < 20; p++) begin
      pix(p, p == 0);
      if (p < 16) begin
        chk($sformatf("gap_valid_p%0d", p), out_valid, 0);
      end else begin
        chk($sformatf("gap_valid_p%0d", p), out_valid, 1);
        chk($sformatf("gap_slice_p%0d", p), d_out,
            mk(p, p - 4, p - 8, p - 12, p - 16));
        chk($sformatf("gap_eol_p%0d", p), out_eol, p == 19);
      end
      idle();
      chk($sformatf("gap_idle_valid_p%0d", p), out_valid, 0);
    end

    // Clamp: width 0 selects MAX_W
    cfg_width = 0;
    for (int p = 0; p < 32; p++) begin
      pix(p, p == 0);
      chk($sformatf("clamp_valid_p%0d", p), out_valid, 0);
    end
    pix(32, 1'b0);
    chk("clamp_valid_p32", out_valid, 1);
    chk("clamp_slice_p32", d_out, mk(32, 24, 16, 8, 0));
    pix(33, 1'b0);
    chk("clamp_slice_p33", d_out, mk(33, 25, 17, 9, 1));

    // Asynchronous reset mid-line
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_d_out",     d_out,     0);
    chk("arst_in_ready",  in_ready,  1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // No SOF after reset: width defaults to MAX_W, full refill required
    for (int p = 0; p < 32; p++) begin
      pix(200 + p, 1'b0);
      chk($sformatf("post_rst_valid_p%0d", p), out_valid, 0);
    end
    pix(232, 1'b0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_slice", d_out, mk(232, 224, 216, 208, 200));
    chk("post_rst_eol",   out_eol, 0);
    for (int p = 233; p < 240; p++) begin
      pix(p, 1'b0);
    end
    chk("post_rst_p239_slice", d_out, mk(239, 231, 223, 215, 207));
    chk("post_rst_p239_eol",   out_eol, 1);

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
